knn_img: RTL and testbench

KNN_IMG -- requirements
Module: knn_img

---
 rtl/knn_img.sv | 186 ++++++++++++++++++
 tb/tb_knn_img.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_img.sv
// ---------------------------------------------------------------------------
// knn_img -- walks an 8x8 grid of cells laid over a rectangular box.
//
// A start is accepted in IDLE when knn_en and dic_end are both 1 on a rising
// clock edge. The box corners can be given in either order. On that edge the
// box origin and the cell size are captured. The block then presents one cell
// per clock in row-major order (row = cnt_h_o outer, column = cnt_w_o inner),
// 64 cells in all. After the last cell it raises knn_fin_o for a single cycle
// and returns to IDLE.
//
// Ports
//   clk_en                      clock (all state changes on its rising edge)
//   reset_n                     asynchronous reset, active HIGH despite name
//   dic_end                     start qualifier (dictionary loaded)
//   knn_en                      start request, level sampled
//   postion_lu_x/_y [9:0]       first box corner
//   postion_rd_x/_y [9:0]       opposite box corner
//   i_o, j_o [9:0]              top-left corner of the current cell
//   cnt_w_o, cnt_h_o [3:0]      column / row index of the current cell
//   wid_center_o, hei_center_o  centre of the current cell
//   knn_fin_o                   one-cycle scan-complete pulse
// ---------------------------------------------------------------------------
module knn_img (
   input  logic       clk_en,
   input  logic       reset_n,
   input  logic       dic_end,
   input  logic       knn_en,
   input  logic [9:0] postion_lu_x,
   input  logic [9:0] postion_lu_y,
   input  logic [9:0] postion_rd_x,
   input  logic [9:0] postion_rd_y,
   output logic [9:0] i_o,
   output logic [9:0] j_o,
   output logic [3:0] cnt_w_o,
   output logic [3:0] cnt_h_o,
   output logic [9:0] wid_center_o,
   output logic [9:0] hei_center_o,
   output logic       knn_fin_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg, state_next;

   // Geometry captured at the start edge.
   logic [9:0] x0_reg, x0_next;
   logic [9:0] y0_reg, y0_next;
   logic [9:0] cw_reg, cw_next;
   logic [9:0] ch_reg, ch_next;

   // Cell counters and coordinate accumulators (these are the outputs).
   logic [2:0] cnt_w_reg, cnt_w_next;
   logic [2:0] cnt_h_reg, cnt_h_next;
   logic [9:0] i_reg, i_next;
   logic [9:0] j_reg, j_next;
   logic [9:0] wc_reg, wc_next;
   logic [9:0] hc_reg, hc_next;
   logic       fin_reg, fin_next;

   // Corner-order-independent box origin and extent.
   logic [9:0] lo_x, lo_y, span_x, span_y;

   always_comb begin
      if (postion_lu_x < postion_rd_x) begin
         lo_x   = postion_lu_x;
         span_x = postion_rd_x - postion_lu_x;
      end else begin
         lo_x   = postion_rd_x;
         span_x = postion_lu_x - postion_rd_x;
      end
      if (postion_lu_y < postion_rd_y) begin
         lo_y   = postion_lu_y;
         span_y = postion_rd_y - postion_lu_y;
      end else begin
         lo_y   = postion_rd_y;
         span_y = postion_lu_y - postion_rd_y;
      end
   end

   // Next-state and datapath. Coordinates are built by repeated addition:
   // one cell width per column step, and at a row change the x accumulator
   // reloads the origin while y gains one cell height. All sums wrap mod 1024.
   always_comb begin
      state_next = state_reg;
      x0_next    = x0_reg;
      y0_next    = y0_reg;
      cw_next    = cw_reg;
      ch_next    = ch_reg;
      cnt_w_next = cnt_w_reg;
      cnt_h_next = cnt_h_reg;
      i_next     = i_reg;
      j_next     = j_reg;
      wc_next    = wc_reg;
      hc_next    = hc_reg;
      fin_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (knn_en && dic_end) begin
               state_next = SCAN;
               x0_next    = lo_x;
               y0_next    = lo_y;
               cw_next    = span_x >> 3;
               ch_next    = span_y >> 3;
               cnt_w_next = 3'd0;
               cnt_h_next = 3'd0;
               i_next     = lo_x;
               j_next     = lo_y;
               // Half a cell is the extent shifted by four.
               wc_next    = lo_x + (span_x >> 4);
               hc_next    = lo_y + (span_y >> 4);
            end
         end

         SCAN: begin
            if (cnt_w_reg != 3'd7) begin
               cnt_w_next = cnt_w_reg + 3'd1;
               i_next     = i_reg + cw_reg;
               wc_next    = i_reg + cw_reg + (cw_reg >> 1);
            end else if (cnt_h_reg != 3'd7) begin
               cnt_w_next = 3'd0;
               cnt_h_next = cnt_h_reg + 3'd1;
               i_next     = x0_reg;
               j_next     = j_reg + ch_reg;
               wc_next    = x0_reg + (cw_reg >> 1);
               hc_next    = j_reg + ch_reg + (ch_reg >> 1);
            end else begin
               // Last cell shown; outputs hold while the finish pulse goes out.
               state_next = DONE;
               fin_next   = 1'b1;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_en or posedge reset_n) begin
      if (reset_n) begin
         state_reg <= IDLE;
         x0_reg    <= '0;
         y0_reg    <= '0;
         cw_reg    <= '0;
         ch_reg    <= '0;
         cnt_w_reg <= '0;
         cnt_h_reg <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         wc_reg    <= '0;
         hc_reg    <= '0;
         fin_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         x0_reg    <= x0_next;
         y0_reg    <= y0_next;
         cw_reg    <= cw_next;
         ch_reg    <= ch_next;
         cnt_w_reg <= cnt_w_next;
         cnt_h_reg <= cnt_h_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         wc_reg    <= wc_next;
         hc_reg    <= hc_next;
         fin_reg   <= fin_next;
      end
   end

   assign i_o          = i_reg;
   assign j_o          = j_reg;
   assign cnt_w_o      = {1'b0, cnt_w_reg};
   assign cnt_h_o      = {1'b0, cnt_h_reg};
   assign wid_center_o = wc_reg;
   assign hei_center_o = hc_reg;
   assign knn_fin_o    = fin_reg;

endmodule

// File: tb/tb_knn_img.sv
// ---------------------------------------------------------------------------
// tb_knn_img -- self-checking bench for knn_img.
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// cell values come from a plain-arithmetic model of the box/grid geometry.
// ---------------------------------------------------------------------------
module tb_knn_img;

   logic       clk;
   logic       rst;
   logic       dic_end;
   logic       knn_en;
   logic [9:0] lu_x, lu_y, rd_x, rd_y;
   logic [9:0] i_o, j_o, wid_center_o, hei_center_o;
   logic [3:0] cnt_w_o, cnt_h_o;
   logic       knn_fin_o;

   int errors = 0;
   int checks = 0;

   logic [48:0] obs;
   logic [48:0] exp_v;

   assign obs = {i_o, j_o, cnt_w_o, cnt_h_o, wid_center_o, hei_center_o, knn_fin_o};

   knn_img dut (
      .clk_en       (clk),
      .reset_n      (rst),
      .dic_end      (dic_end),
      .knn_en       (knn_en),
      .postion_lu_x (lu_x),
      .postion_lu_y (lu_y),
      .postion_rd_x (rd_x),
      .postion_rd_y (rd_y),
      .i_o          (i_o),
      .j_o          (j_o),
      .cnt_w_o      (cnt_w_o),
      .cnt_h_o      (cnt_h_o),
      .wid_center_o (wid_center_o),
      .hei_center_o (hei_center_o),
      .knn_fin_o    (knn_fin_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for cell number k (0..63, row-major) of a box.
   // Packed as {i, j, cnt_w, cnt_h, wid_center, hei_center, fin=0}.
   function automatic logic [48:0] model(input int ax, input int ay,
                                         input int bx, input int by, input int k);
      int x0, y0, cw, ch, w, h, i, j, wc, hc;
      x0 = (ax < bx) ? ax : bx;
      y0 = (ay < by) ? ay : by;
      cw = ((ax > bx) ? ax - bx : bx - ax) / 8;
      ch = ((ay > by) ? ay - by : by - ay) / 8;
      w  = k % 8;
      h  = k / 8;
      i  = (x0 + w * cw) % 1024;
      j  = (y0 + h * ch) % 1024;
      wc = (i + cw / 2) % 1024;
      hc = (j + ch / 2) % 1024;
      return {10'(i), 10'(j), 4'(w), 4'(h), 10'(wc), 10'(hc), 1'b0};
   endfunction

   task automatic test_reset();
      knn_en  = 1'b1;
      dic_end = 1'b1;
      lu_x = 10'd100; lu_y = 10'd400; rd_x = 10'd300; rd_y = 10'd200;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 49'd0) begin
         errors++;
         $display("FAIL reset_initial got=%h exp=%h", obs, 49'd0);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== 49'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs, 49'd0);
         end
      end
      knn_en  = 1'b0;
      dic_end = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 49'd0) begin
         errors++;
         $display("FAIL reset_release got=%h exp=%h", obs, 49'd0);
      end
      $display("test_reset done");
   endtask

   task automatic test_dic_gate();
      int ax, ay, bx, by;
      ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
      bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
      knn_en  = 1'b1;
      dic_end = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== 49'd0) begin
            errors++;
            $display("FAIL dic_gate_idle cyc=%0d got=%h exp=%h", c, obs, 49'd0);
         end
      end
      dic_end = 1'b1;
      @(negedge clk);
      knn_en = 1'b0;
      for (int k = 0; k < 64; k++) begin
         exp_v = model(ax, ay, bx, by, k);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL dic_gate_cell k=%0d got=%h exp=%h", k, obs, exp_v);
         end
         @(negedge clk);
      end
      exp_v = model(ax, ay, bx, by, 63) | 49'd1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL dic_gate_fin got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      exp_v = model(ax, ay, bx, by, 63);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL dic_gate_hold got=%h exp=%h", obs, exp_v);
      end
      $display("test_dic_gate box=(%0d,%0d)-(%0d,%0d) done", ax, ay, bx, by);
   endtask

   // The worked box, once as given and once with corners swapped.
   task automatic test_directed();
      int ax, ay, bx, by;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin ax = 100; ay = 400; bx = 300; by = 200; end
         else           begin ax = 300; ay = 200; bx = 100; by = 400; end
         lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
         knn_en  = 1'b1;
         dic_end = 1'b1;
         @(negedge clk);
         knn_en = 1'b0;
         for (int k = 0; k < 64; k++) begin
            exp_v = model(ax, ay, bx, by, k);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL directed_cell pass=%0d k=%0d got=%h exp=%h", pass, k, obs, exp_v);
            end
            if (k == 0) begin
               checks++;
               if ({i_o, j_o, wid_center_o, hei_center_o} !==
                   {10'd100, 10'd200, 10'd112, 10'd212}) begin
                  errors++;
                  $display("FAIL directed_first pass=%0d got=%0d,%0d,%0d,%0d exp=100,200,112,212",
                           pass, i_o, j_o, wid_center_o, hei_center_o);
               end
            end
            if (k == 1) begin
               checks++;
               if ({i_o, wid_center_o} !== {10'd125, 10'd137}) begin
                  errors++;
                  $display("FAIL directed_second pass=%0d got=%0d,%0d exp=125,137",
                           pass, i_o, wid_center_o);
               end
            end
            if (k == 63) begin
               checks++;
               if ({i_o, j_o, wid_center_o, hei_center_o, knn_fin_o} !==
                   {10'd275, 10'd375, 10'd287, 10'd387, 1'b0}) begin
                  errors++;
                  $display("FAIL directed_last pass=%0d got=%0d,%0d,%0d,%0d fin=%0d exp=275,375,287,387 fin=0",
                           pass, i_o, j_o, wid_center_o, hei_center_o, knn_fin_o);
               end
            end
            @(negedge clk);
         end
         exp_v = model(ax, ay, bx, by, 63) | 49'd1;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL directed_fin pass=%0d got=%h exp=%h", pass, obs, exp_v);
         end
         @(negedge clk);
         exp_v = model(ax, ay, bx, by, 63);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL directed_hold pass=%0d got=%h exp=%h", pass, obs, exp_v);
         end
         $display("test_directed pass=%0d done", pass);
      end
   endtask

   // Zero-size, full-range and random boxes.
   task automatic test_random_boxes();
      int ax, ay, bx, by;
      for (int n = 0; n < 7; n++) begin
         case (n)
            0:       begin ax = 50;   ay = 60;   bx = 50; by = 500; end
            1:       begin ax = 10;   ay = 10;   bx = 17; by = 9;   end
            2:       begin ax = 1023; ay = 1023; bx = 0;  by = 0;   end
            default: begin
               ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
               bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
            end
         endcase
         lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
         knn_en  = 1'b1;
         dic_end = 1'b1;
         @(negedge clk);
         knn_en = 1'b0;
         for (int k = 0; k < 64; k++) begin
            exp_v = model(ax, ay, bx, by, k);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL random_cell n=%0d k=%0d got=%h exp=%h", n, k, obs, exp_v);
            end
            @(negedge clk);
         end
         exp_v = model(ax, ay, bx, by, 63) | 49'd1;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random_fin n=%0d got=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
         exp_v = model(ax, ay, bx, by, 63);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random_hold n=%0d got=%h exp=%h", n, obs, exp_v);
         end
         $display("test_random_boxes n=%0d box=(%0d,%0d)-(%0d,%0d) done", n, ax, ay, bx, by);
      end
   endtask

   // Inputs thrashed during the scan must have no effect.
   task automatic test_ignore_midscan();
      int ax, ay, bx, by;
      ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
      bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
      knn_en  = 1'b1;
      dic_end = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
         exp_v = model(ax, ay, bx, by, k);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL midscan_cell k=%0d got=%h exp=%h", k, obs, exp_v);
         end
         knn_en  = 1'($urandom_range(0, 1));
         dic_end = 1'($urandom_range(0, 1));
         lu_x = 10'($urandom_range(0, 1023)); lu_y = 10'($urandom_range(0, 1023));
         rd_x = 10'($urandom_range(0, 1023)); rd_y = 10'($urandom_range(0, 1023));
         @(negedge clk);
      end
      knn_en  = 1'b0;
      dic_end = 1'b1;
      exp_v = model(ax, ay, bx, by, 63) | 49'd1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL midscan_fin got=%h exp=%h", obs, exp_v);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         exp_v = model(ax, ay, bx, by, 63);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL midscan_after cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      $display("test_ignore_midscan done");
   endtask

   // knn_en held high restarts on the first IDLE cycle after DONE.
   task automatic test_back_to_back();
      int ax, ay, bx, by, cx, cy, dx, dy;
      ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
      bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      cx = $urandom_range(0, 1023); cy = $urandom_range(0, 1023);
      dx = $urandom_range(0, 1023); dy = $urandom_range(0, 1023);
      lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
      knn_en  = 1'b1;
      dic_end = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
         exp_v = model(ax, ay, bx, by, k);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_first k=%0d got=%h exp=%h", k, obs, exp_v);
         end
         if (k == 5) begin
            lu_x = 10'(cx); lu_y = 10'(cy); rd_x = 10'(dx); rd_y = 10'(dy);
         end
         @(negedge clk);
      end
      exp_v = model(ax, ay, bx, by, 63) | 49'd1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_fin1 got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      exp_v = model(ax, ay, bx, by, 63);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_idle got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      knn_en = 1'b0;
      for (int k = 0; k < 64; k++) begin
         exp_v = model(cx, cy, dx, dy, k);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_second k=%0d got=%h exp=%h", k, obs, exp_v);
         end
         @(negedge clk);
      end
      exp_v = model(cx, cy, dx, dy, 63) | 49'd1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_fin2 got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      exp_v = model(cx, cy, dx, dy, 63);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_hold got=%h exp=%h", obs, exp_v);
      end
      $display("test_back_to_back done");
   endtask

   // Reset at cell (3,2) clears outputs at once and no finish pulse follows.
   task automatic test_reset_midscan();
      int ax, ay, bx, by;
      ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
      bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      lu_x = 10'(ax); lu_y = 10'(ay); rd_x = 10'(bx); rd_y = 10'(by);
      knn_en  = 1'b1;
      dic_end = 1'b1;
      @(negedge clk);
      knn_en = 1'b0;
      repeat (19) @(negedge clk);
      exp_v = model(ax, ay, bx, by, 19);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rstmid_cell32 got=%h exp=%h", obs, exp_v);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== 49'd0) begin
         errors++;
         $display("FAIL rstmid_clear got=%h exp=%h", obs, 49'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== 49'd0) begin
            errors++;
            $display("FAIL rstmid_quiet cyc=%0d got=%h exp=%h", c, obs, 49'd0);
         end
      end
      $display("test_reset_midscan done");
   endtask

   initial begin
      test_reset();
      test_dic_gate();
      test_directed();
      test_random_boxes();
      test_ignore_midscan();
      test_back_to_back();
      test_reset_midscan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
